serial_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/serial_receiver.sv | 161 ++++++++++++++++
 tb/tb_serial_receiver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, data width and receiver FSM states.
package uart_pkg;

  localparam int CYCLES_PER_BIT_DEFAULT = 625;  // 6 MHz / 9600 baud
  localparam int DATA_BITS              = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; RESET_VAL sets the idle level.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= RESET_VAL;
      q_reg    <= RESET_VAL;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/serial_receiver.sv
// 8N1 UART receiver with valid/ready byte delivery, framing-error and overrun pulses.
// Define SERIAL_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each sample point.
module serial_receiver
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT,
  parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_framing_error,
  output logic       rx_overrun
);

`ifdef SERIAL_RX_MAJORITY_VOTE_EN
  // Decision is taken one cycle late, so the counter must reach CYCLES_PER_BIT+1.
  localparam int TICK_W     = $clog2(CYCLES_PER_BIT + 2);
  localparam int SAMPLE_OFS = 1;
`else
  localparam int TICK_W     = $clog2(CYCLES_PER_BIT + 1);
  localparam int SAMPLE_OFS = 0;
`endif
  localparam logic [TICK_W-1:0] TICK_RESTART = TICK_W'(SAMPLE_OFS);
  localparam logic [TICK_W-1:0] START_AT     = TICK_W'(HALF_BIT + SAMPLE_OFS);
  localparam logic [TICK_W-1:0] BIT_AT       = TICK_W'(CYCLES_PER_BIT + SAMPLE_OFS);
  localparam int                IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 sample_bit;
  rx_state_t            state_reg;
  logic [TICK_W-1:0]    tick_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [7:0]           rx_data_reg;
  logic                 rx_valid_reg;
  logic                 framing_error_reg;
  logic                 overrun_reg;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (serial_rx),
    .q       (rx_s)
  );

`ifdef SERIAL_RX_MAJORITY_VOTE_EN
  // hist_reg[0] is rx_s at tick, hist_reg[1] at tick-1; rx_s itself is tick+1.
  logic [1:0] hist_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign sample_bit = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      tick_reg          <= '0;
      bit_idx_reg       <= '0;
      shift_reg         <= '0;
      rx_data_reg       <= '0;
      rx_valid_reg      <= 1'b0;
      framing_error_reg <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      framing_error_reg <= 1'b0;
      overrun_reg       <= 1'b0;
      if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          tick_reg    <= '0;
          bit_idx_reg <= '0;
          if (!rx_s) begin
            state_reg <= START;
          end
        end
        START: begin
          if (tick_reg == START_AT) begin
            if (!sample_bit) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
              tick_reg    <= TICK_RESTART;
            end else begin
              state_reg <= IDLE;
              tick_reg  <= '0;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end
        DATA: begin
          if (tick_reg == BIT_AT) begin
            shift_reg[bit_idx_reg] <= sample_bit;
            bit_idx_reg            <= bit_idx_reg + 1'b1;
            tick_reg               <= TICK_RESTART;
            if (bit_idx_reg == LAST_IDX) begin
              state_reg <= STOP;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end
        STOP: begin
          if (tick_reg == BIT_AT) begin
            tick_reg <= '0;
            if (sample_bit) begin
              state_reg <= IDLE;
              // A consume on this same edge frees the holding register for the new byte.
              if (!rx_valid_reg || rx_ready) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
              end else begin
                overrun_reg <= 1'b1;
              end
            end else begin
              framing_error_reg <= 1'b1;
              state_reg         <= WAIT_HIGH;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end
        WAIT_HIGH: begin
          tick_reg <= '0;
          if (rx_s) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          tick_reg  <= '0;
        end
      endcase
    end
  end

  assign rx_data          = rx_data_reg;
  assign rx_valid         = rx_valid_reg;
  assign rx_framing_error = framing_error_reg;
  assign rx_overrun       = overrun_reg;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: frames are driven on serial_rx, expected bytes are
// queued as each frame is sent and compared when the parent side consumes them.
module tb_serial_receiver;
  import uart_pkg::*;

  localparam int CPB = 625;

  logic       clock;
  logic       reset_n;
  logic       serial_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_framing_error;
  logic       rx_overrun;

  int         checks    = 0;
  int         failures  = 0;
  int         cyc       = 0;
  int         fe_count  = 0;
  int         ov_count  = 0;
  int         rise_cyc  = -1;
  logic       valid_d   = 1'b0;
  logic [7:0] exp_q[$];

  serial_receiver #(
    .CYCLES_PER_BIT (CPB)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .serial_rx        (serial_rx),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_framing_error (rx_framing_error),
    .rx_overrun       (rx_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: counts pulses, timestamps rx_valid rises and scores every consumed byte.
  always @(negedge clock) begin
    logic [8:0] exp9;
    if (rx_framing_error) fe_count++;
    if (rx_overrun) ov_count++;
    if (rx_valid && !valid_d) rise_cyc = cyc;
    valid_d = rx_valid;
    if (reset_n && rx_valid && rx_ready) begin
      exp9 = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
      checks++;
      assert ({1'b0, rx_data} === exp9)
      else begin
        failures++;
        $error("FAIL consumed_byte observed=%0h expected=%0h (100 = no byte expected)", rx_data, exp9);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    serial_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      hold(CPB);
    end
    serial_rx = stop_val;
    hold(CPB);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    hold(1);
    rx_ready = 1'b0;
    hold(1);
  endtask

  initial begin
    int         start_cyc;
    int         fe0;
    int         ov0;
    logic [7:0] b;

    reset_n   = 1'b0;
    serial_rx = 1'b1;
    rx_ready  = 1'b0;
    hold(5);
    reset_n = 1'b1;
    hold(5);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_fe_count", 32'(fe_count), 32'd0);
    check("reset_ov_count", 32'(ov_count), 32'd0);

    // 0xA5 with rx_ready low: latency, hold until consumed
    exp_q.push_back(8'hA5);
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    check("a5_latency_in_window", 32'((rise_cyc - start_cyc) >= 5900 && (rise_cyc - start_cyc) <= 6000), 32'd1);
    hold(300);
    check("a5_valid_held", 32'(rx_valid), 32'd1);
    check("a5_data", 32'(rx_data), 32'hA5);
    consume();
    check("a5_valid_cleared", 32'(rx_valid), 32'd0);
    check("a5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 200-cycle glitch on idle line
    fe0 = fe_count;
    serial_rx = 1'b0;
    hold(200);
    serial_rx = 1'b1;
    hold(400);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);
    check("glitch_no_fe", 32'(fe_count - fe0), 32'd0);
    check("glitch_state_idle", 32'(dut.state_reg), 32'(IDLE));

    // Framing error with line held low, then recovery frame
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    hold(2000);
    check("break_state_wait_high", 32'(dut.state_reg), 32'(WAIT_HIGH));
    serial_rx = 1'b1;
    hold(700);
    check("framing_pulse_once", 32'(fe_count - fe0), 32'd1);
    check("framing_no_valid", 32'(rx_valid), 32'd0);
    check("framing_state_idle", 32'(dut.state_reg), 32'(IDLE));
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    check("after_break_data", 32'(rx_data), 32'h11);
    consume();

    // Overrun: 0x01 then 0x02 back-to-back, rx_ready low
    ov0 = ov_count;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    check("overrun_pulse_once", 32'(ov_count - ov0), 32'd1);
    check("overrun_data_kept", 32'(rx_data), 32'h01);
    check("overrun_valid", 32'(rx_valid), 32'd1);
    consume();
    check("overrun_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same pair with rx_ready tied high
    ov0 = ov_count;
    rx_ready = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    hold(20);
    rx_ready = 1'b0;
    hold(2);
    check("ready_high_no_overrun", 32'(ov_count - ov0), 32'd0);
    check("ready_high_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ready_high_valid_low", 32'(rx_valid), 32'd0);

    // Reset during data bit 4, then 0x7E
    b = 8'hC3;
    serial_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      serial_rx = b[i];
      hold(CPB);
    end
    serial_rx = b[4];
    hold(300);
    reset_n = 1'b0;
    hold(2);
    check("midreset_data_zero", 32'(rx_data), 32'd0);
    check("midreset_state_idle", 32'(dut.state_reg), 32'(IDLE));
    serial_rx = 1'b1;
    hold(2);
    reset_n = 1'b1;
    hold(1000);
    check("midreset_no_partial", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    check("midreset_7e_valid", 32'(rx_valid), 32'd1);
    check("midreset_7e_data", 32'(rx_data), 32'h7E);
    consume();

    // Transmitter-style stream 0x00, 0xFF, 0x55 with rx_ready high
    ov0 = ov_count;
    fe0 = fe_count;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    hold(20);
    rx_ready = 1'b0;
    hold(2);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    check("stream_no_overrun", 32'(ov_count - ov0), 32'd0);
    check("stream_no_fe", 32'(fe_count - fe0), 32'd0);

`ifdef SERIAL_RX_MAJORITY_VOTE_EN
    // 0x5A with a one-cycle inverted glitch in the middle of every sample triplet
    begin
      logic [9:0] frame;
      logic       lvl;
      frame = {1'b1, 8'h5A, 1'b0};
      exp_q.push_back(8'h5A);
      for (int o = 0; o < 10 * CPB; o++) begin
        lvl = frame[o / CPB];
        if (o == 313) lvl = ~lvl;
        for (int k = 0; k < 9; k++) begin
          if (o == 939 + 626 * k) lvl = ~lvl;
        end
        serial_rx = lvl;
        hold(1);
      end
      serial_rx = 1'b1;
      hold(20);
      check("vote_valid", 32'(rx_valid), 32'd1);
      check("vote_data", 32'(rx_data), 32'h5A);
      consume();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
